bp_be_nonsynth_dcache_resp_buffer: RTL and testbench

- Response-side stage of the D$ trace bench. Sits between the D$ wrapper's load-data output (v/data, no backpressure honoured) and the trace-replay receive port.
- Buffers returned dwords in an N-entry circular queue, zero-extends them to the replay payload width, and optionally injects pseudo-random consumer stalls.
- Flags overflow and keeps response/occupancy statistics.
- Replaces the generic FIFO plus random-yumi pair with one checked block.

---
 rtl/bp_be_nonsynth_dcache_resp_buffer.sv | 135 +++++++++++++
 tb/tb_bp_be_nonsynth_dcache_resp_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bp_be_nonsynth_dcache_resp_buffer.sv
// D$ response buffer for the trace bench: circular queue, zero-extension to the replay width,
// overflow flag and statistics. Define BP_DCACHE_RESP_RANDOM_STALL_EN to enable LFSR consumer stalls.
module bp_be_nonsynth_dcache_resp_buffer #(
  parameter int unsigned data_width_p     = 64,
  parameter int unsigned out_width_p      = 128,
  parameter int unsigned els_p            = 8,
  parameter logic [15:0] stall_seed_p     = 16'hACE1,
  parameter logic [3:0]  stall_mask_p     = 4'hF,
  parameter bit          overflow_error_p = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  input  logic [data_width_p-1:0]      data_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [out_width_p-1:0]       data_o,
  input  logic                         ready_and_i,
  output logic                         empty_o,
  output logic                         overflow_o,
  output logic [31:0]                  resp_count_o,
  output logic [$clog2(els_p):0]       max_occ_o
);

  localparam int unsigned ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w = $clog2(els_p) + 1;

  if ((out_width_p < data_width_p) || (els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_cfg
    $error("bp_be_nonsynth_dcache_resp_buffer: out_width_p must be >= data_width_p and els_p a power of two >= 2");
  end

  typedef enum logic {e_run, e_stall} state_e;

  logic [data_width_p-1:0] mem [els_p];
  logic [ptr_w-1:0] rptr_r, wptr_r;
  logic [cnt_w-1:0] count_r, count_n;
  logic [cnt_w-1:0] max_occ_r;
  logic [31:0]      resp_count_r;
  logic             overflow_r;
  logic             enq, deq, ovf_evt;
  state_e           state_r;

  assign ready_o      = ~reset_i & (count_r < cnt_w'(els_p));
  assign v_o          = (count_r != '0) & (state_r == e_run) & ~reset_i;
  assign empty_o      = reset_i | (count_r == '0);
  assign data_o       = out_width_p'(mem[rptr_r]);
  assign overflow_o   = overflow_r;
  assign resp_count_o = resp_count_r;
  assign max_occ_o    = max_occ_r;

  assign enq     = v_i & ready_o;
  assign deq     = v_o & ready_and_i;
  assign ovf_evt = v_i & ~ready_o & ~reset_i;

  always_comb begin
    count_n = count_r;
    if (enq && !deq)      count_n = count_r + cnt_w'(1);
    else if (deq && !enq) count_n = count_r - cnt_w'(1);
  end

  // Storage has no reset; only entries between rptr and wptr are ever observed.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r       <= '0;
      wptr_r       <= '0;
      count_r      <= '0;
      max_occ_r    <= '0;
      resp_count_r <= '0;
      overflow_r   <= 1'b0;
    end else begin
      if (enq) begin
        wptr_r       <= wptr_r + ptr_w'(1);
        resp_count_r <= resp_count_r + 32'd1;
      end
      if (deq) rptr_r <= rptr_r + ptr_w'(1);
      count_r <= count_n;
      if (count_n > max_occ_r) max_occ_r <= count_n;
      if (ovf_evt) overflow_r <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (overflow_error_p && ovf_evt)
      $error("bp_be_nonsynth_dcache_resp_buffer: response dropped, queue full");
  end

`ifdef BP_DCACHE_RESP_RANDOM_STALL_EN
  localparam logic [15:0] seed_lp = (stall_seed_p == 16'h0) ? 16'h0001 : stall_seed_p;

  state_e      state_n;
  logic [3:0]  stall_cnt_r, stall_cnt_n, stall_len;
  logic [15:0] lfsr_r, lfsr_n;

  assign stall_len = lfsr_r[3:0] & stall_mask_p;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_n = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    state_n     = state_r;
    stall_cnt_n = stall_cnt_r;
    case (state_r)
      e_run: begin
        if (deq && (stall_len != 4'h0)) begin
          state_n     = e_stall;
          stall_cnt_n = stall_len;
        end
      end
      e_stall: begin
        stall_cnt_n = stall_cnt_r - 4'd1;
        if (stall_cnt_r == 4'd1) state_n = e_run;
      end
      default: state_n = e_run;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_run;
      stall_cnt_r <= 4'h0;
      lfsr_r      <= seed_lp;
    end else begin
      state_r     <= state_n;
      stall_cnt_r <= stall_cnt_n;
      lfsr_r      <= lfsr_n;
    end
  end
`else
  assign state_r = e_run;
`endif

endmodule

// File: tb/tb_bp_be_nonsynth_dcache_resp_buffer.sv
// Directed bench for bp_be_nonsynth_dcache_resp_buffer: vector table plus multi-cycle sequences.
module tb_bp_be_nonsynth_dcache_resp_buffer;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         v_i = 1'b0;
  logic [63:0]  data_i = '0;
  logic         ready_o;
  logic         v_o;
  logic [127:0] data_o;
  logic         ready_and_i = 1'b0;
  logic         empty_o;
  logic         overflow_o;
  logic [31:0]  resp_count_o;
  logic [3:0]   max_occ_o;

  always #5 clk_i = ~clk_i;

  bp_be_nonsynth_dcache_resp_buffer #(.overflow_error_p(1'b0)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .ready_and_i(ready_and_i), .empty_o(empty_o),
    .overflow_o(overflow_o), .resp_count_o(resp_count_o), .max_occ_o(max_occ_o)
  );

  typedef struct {
    logic        rst; logic v; logic [63:0] d; logic rdy;
    logic        e_ready; logic e_v; logic [63:0] e_d; logic e_empty;
    logic        e_ovf; logic [31:0] e_resp; logic [3:0] e_max;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void add(input logic rst, input logic v, input logic [63:0] d, input logic rdy,
                              input logic er, input logic ev, input logic [63:0] ed, input logic ee,
                              input logic eo, input logic [31:0] eresp, input logic [3:0] emax);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.rdy = rdy;
    t.e_ready = er; t.e_v = ev; t.e_d = ed; t.e_empty = ee;
    t.e_ovf = eo; t.e_resp = eresp; t.e_max = emax;
    vecs.push_back(t);
  endfunction

  // Drive one cycle against the in-order reference queue (no-stall build only).
  task automatic cyc(input logic v, input logic [63:0] d, input logic rdy);
    logic enq, deq;
    chk("seq v_o", 128'(v_o), 128'(q.size() != 0));
    if (v_o && q.size() != 0) chk("seq data_o", data_o, {64'h0, q[0]});
    enq = v & ready_o;
    deq = v_o & rdy;
    v_i = v; data_i = d; ready_and_i = rdy;
    step();
    if (deq && q.size() != 0) void'(q.pop_front());
    if (enq) q.push_back(d);
    v_i = 1'b0;
  endtask

  initial begin
    // reset, single beat and handshake
    add(1, 0, 64'h0, 0,                    0, 0, 64'h0, 1, 0, 0, 0);
    add(0, 1, 64'hDEAD_BEEF_0123_4567, 1,  1, 1, 64'hDEAD_BEEF_0123_4567, 0, 0, 1, 1);
    add(0, 0, 64'h0, 1,                    1, 0, 64'h0, 1, 0, 1, 1);
    // fill to full with pointers offset by one, so the write pointer wraps
    for (int k = 1; k <= 8; k++)
      add(0, 1, 64'(k), 0, (k < 8), 1, 64'h1, 0, 0, 32'(1 + k), 4'(k));
    // ninth beat dropped, overflow sticky
    add(0, 1, 64'h99, 0,  0, 1, 64'h1, 0, 1, 9, 8);
    add(0, 0, 64'h0, 0,   0, 1, 64'h1, 0, 1, 9, 8);
    for (int i = 1; i <= 8; i++)
      add(0, 0, 64'h0, 1, 1, (i < 8), 64'(i + 1), (i == 8), 1, 9, 8);
    add(1, 0, 64'h0, 0,   0, 0, 64'h0, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset_i = vecs[i].rst; v_i = vecs[i].v; data_i = vecs[i].d; ready_and_i = vecs[i].rdy;
      step();
      chk($sformatf("row%0d ready_o", i), 128'(ready_o), 128'(vecs[i].e_ready));
      chk($sformatf("row%0d v_o", i), 128'(v_o), 128'(vecs[i].e_v));
      if (vecs[i].e_v) chk($sformatf("row%0d data_o", i), data_o, {64'h0, vecs[i].e_d});
      chk($sformatf("row%0d empty_o", i), 128'(empty_o), 128'(vecs[i].e_empty));
      chk($sformatf("row%0d overflow_o", i), 128'(overflow_o), 128'(vecs[i].e_ovf));
      chk($sformatf("row%0d resp_count_o", i), 128'(resp_count_o), 128'(vecs[i].e_resp));
      chk($sformatf("row%0d max_occ_o", i), 128'(max_occ_o), 128'(vecs[i].e_max));
    end
    reset_i = 1'b0; v_i = 1'b0; ready_and_i = 1'b0;

`ifndef BP_DCACHE_RESP_RANDOM_STALL_EN
    // steady state at occupancy 4: simultaneous enqueue/dequeue, no gaps
    q.delete();
    step();
    for (int i = 0; i < 4; i++) cyc(1'b1, 64'(16'h100 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 64'(16'h200 + i), 1'b1);
      chk("stream v_o", 128'(v_o), 128'(1));
      chk("stream ready_o", 128'(ready_o), 128'(1));
    end
    chk("stream max_occ_o", 128'(max_occ_o), 128'(4));
    for (int i = 0; i < 4; i++) cyc(1'b0, 64'h0, 1'b1);
    chk("stream empty_o", 128'(empty_o), 128'(1));
    chk("stream resp_count_o", 128'(resp_count_o), 128'(14));
`else
    begin : random_stall
      int sent, got, gap, maxgap, cycles;
      logic v;
      sent = 0; got = 0; gap = 0; maxgap = 0; cycles = 0;
      reset_i = 1'b1; step(); reset_i = 1'b0;
      while (got < 100 && cycles < 5000) begin
        if (v_o) begin
          chk("rand data_o", data_o, 128'(got + 1));
          got++;
          gap = 0;
        end else if (sent > got) begin
          gap++;
          if (gap > maxgap) maxgap = gap;
        end
        v = (sent < 100) && ready_o && ($urandom_range(0, 3) != 0);
        v_i = v; data_i = 64'(sent + 1); ready_and_i = 1'b1;
        if (v) sent++;
        step();
        cycles++;
      end
      v_i = 1'b0;
      chk("rand beats received", 128'(got), 128'(100));
      chk("rand some gap", 128'(maxgap > 0), 128'(1));
      chk("rand gap bound", 128'(maxgap <= 15), 128'(1));
      chk("rand overflow_o", 128'(overflow_o), 128'(0));
    end
`endif

    // reset with five entries queued discards them
    reset_i = 1'b1; step(); reset_i = 1'b0;
    ready_and_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v_i = 1'b1; data_i = 64'(16'h500 + i);
      step();
    end
    v_i = 1'b0;
    chk("pre-reset empty_o", 128'(empty_o), 128'(0));
    reset_i = 1'b1; ready_and_i = 1'b1;
    step();
    chk("reset v_o", 128'(v_o), 128'(0));
    chk("reset empty_o", 128'(empty_o), 128'(1));
    chk("reset ready_o", 128'(ready_o), 128'(0));
    chk("reset overflow_o", 128'(overflow_o), 128'(0));
    chk("reset resp_count_o", 128'(resp_count_o), 128'(0));
    reset_i = 1'b0; ready_and_i = 1'b0;
    step();
    chk("post-reset max_occ_o", 128'(max_occ_o), 128'(0));
    v_i = 1'b1; data_i = 64'h1;
    step();
    v_i = 1'b0;
    chk("post-reset v_o", 128'(v_o), 128'(1));
    chk("post-reset data_o", data_o, 128'h1);
    chk("post-reset resp_count_o", 128'(resp_count_o), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
